conv_window_addr_gen: RTL and testbench

Sliding-window read-address generator for one convolution/pooling layer of the CNN accelerator. It sits directly downstream of the layer sequencer and consumes the sequencer's per-layer `input_width`, `kernal_width` and `stride`. It walks every output position and every kernel tap, emitting feature-map read addresses to the buffer/MAC datapath over a valid/ready handshake. When the layer's last address is accepted, it pulses `next_layer` back to the sequencer.

---
 rtl/conv_window_addr_gen.sv | 177 +++++++++++++++++
 tb/tb_conv_window_addr_gen.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_window_addr_gen.sv
// Sliding-window read-address generator: walks every output window and kernel tap
// of one square feature map and streams row-major addresses over valid/ready.
module conv_window_addr_gen #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [4:0]        input_width,
    input  logic [1:0]        kernal_width,
    input  logic [1:0]        stride,
    output logic              addr_valid,
    input  logic              addr_ready,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              win_first,
    output logic              win_last,
    output logic              busy,
    output logic              err,
    output logic              next_layer,
    output logic [1:0]        state_dbg
);

    // Handshake: an address transfers on a rising edge where addr_valid && addr_ready;
    // once raised, addr_valid and the payload hold until that transfer happens.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [4:0]        w_q, w_d;
    logic [1:0]        k_q, k_d;
    logic [1:0]        s_q, s_d;
    logic [4:0]        base_row_q, base_row_d;
    logic [4:0]        base_col_q, base_col_d;
    logic [1:0]        ky_q, ky_d;
    logic [1:0]        kx_q, kx_d;
    logic [ADDR_W-1:0] row_off_q, row_off_d;
    logic [ADDR_W-1:0] win_off_q, win_off_d;
    logic [ADDR_W-1:0] step_q, step_d;
    logic              err_q, err_d;

    logic              hs;
    logic              kx_end;
    logic              ky_end;
    logic [6:0]        col_end;
    logic [6:0]        row_end;
    logic              col_fits;
    logic              row_fits;
    logic              cfg_bad;

    assign hs       = addr_valid && addr_ready;
    assign kx_end   = (kx_q == k_q - 2'd1);
    assign ky_end   = (ky_q == k_q - 2'd1);
    // Extent of the next window along each axis; 7 bits so 31+3+3 cannot wrap.
    assign col_end  = {2'b00, base_col_q} + {5'd0, s_q} + {5'd0, k_q};
    assign row_end  = {2'b00, base_row_q} + {5'd0, s_q} + {5'd0, k_q};
    assign col_fits = (col_end <= {2'b00, w_q});
    assign row_fits = (row_end <= {2'b00, w_q});
    assign cfg_bad  = (k_q == 2'd0) || (s_q == 2'd0) || ({3'd0, k_q} > w_q);

    always_comb begin
        state_d    = state_q;
        w_d        = w_q;
        k_d        = k_q;
        s_d        = s_q;
        base_row_d = base_row_q;
        base_col_d = base_col_q;
        ky_d       = ky_q;
        kx_d       = kx_q;
        row_off_d  = row_off_q;
        win_off_d  = win_off_q;
        step_d     = step_q;
        err_d      = err_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    w_d     = input_width;
                    k_d     = kernal_width;
                    s_d     = stride;
                    err_d   = 1'b0;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                if (cfg_bad) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    base_row_d = '0;
                    base_col_d = '0;
                    ky_d       = '0;
                    kx_d       = '0;
                    row_off_d  = '0;
                    win_off_d  = '0;
                    step_d     = ADDR_W'({2'b00, w_q}) * ADDR_W'(s_q);
                    state_d    = S_RUN;
                end
            end
            S_RUN: begin
                if (hs) begin
                    if (!kx_end) begin
                        kx_d = kx_q + 2'd1;
                    end else begin
                        kx_d = '0;
                        if (!ky_end) begin
                            ky_d      = ky_q + 2'd1;
                            row_off_d = row_off_q + ADDR_W'(w_q);
                        end else begin
                            ky_d = '0;
                            if (col_fits) begin
                                base_col_d = base_col_q + {3'd0, s_q};
                                row_off_d  = win_off_q;
                            end else if (row_fits) begin
                                base_col_d = '0;
                                base_row_d = base_row_q + {3'd0, s_q};
                                win_off_d  = win_off_q + step_q;
                                row_off_d  = win_off_q + step_q;
                            end else begin
                                state_d = S_DONE;
                            end
                        end
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            w_q        <= '0;
            k_q        <= '0;
            s_q        <= '0;
            base_row_q <= '0;
            base_col_q <= '0;
            ky_q       <= '0;
            kx_q       <= '0;
            row_off_q  <= '0;
            win_off_q  <= '0;
            step_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            w_q        <= w_d;
            k_q        <= k_d;
            s_q        <= s_d;
            base_row_q <= base_row_d;
            base_col_q <= base_col_d;
            ky_q       <= ky_d;
            kx_q       <= kx_d;
            row_off_q  <= row_off_d;
            win_off_q  <= win_off_d;
            step_q     <= step_d;
            err_q      <= err_d;
        end
    end

    // Payload is forced to zero outside RUN so idle outputs match the reset values.
    assign addr_valid = (state_q == S_RUN);
    assign rd_addr    = addr_valid ? (row_off_q + ADDR_W'(base_col_q) + ADDR_W'(kx_q)) : '0;
    assign win_first  = addr_valid && (ky_q == 2'd0) && (kx_q == 2'd0);
    assign win_last   = addr_valid && ky_end && kx_end;
    assign busy       = (state_q == S_SETUP) || (state_q == S_RUN);
    assign err        = err_q;
    assign next_layer = (state_q == S_DONE);
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_conv_window_addr_gen.sv
// Bench for conv_window_addr_gen: a window-walk model fills an expected queue and
// one negedge process checks every valid address, handshake and next_layer pulse.
module tb_conv_window_addr_gen;

    logic       clk;
    logic       reset;
    logic       start;
    logic [4:0] input_width;
    logic [1:0] kernal_width;
    logic [1:0] stride;
    logic       addr_valid;
    logic       addr_ready;
    logic [9:0] rd_addr;
    logic       win_first;
    logic       win_last;
    logic       busy;
    logic       err;
    logic       next_layer;
    logic [1:0] state_dbg;

    conv_window_addr_gen #(.ADDR_W(10)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .input_width  (input_width),
        .kernal_width (kernal_width),
        .stride       (stride),
        .addr_valid   (addr_valid),
        .addr_ready   (addr_ready),
        .rd_addr      (rd_addr),
        .win_first    (win_first),
        .win_last     (win_last),
        .busy         (busy),
        .err          (err),
        .next_layer   (next_layer),
        .state_dbg    (state_dbg)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- bookkeeping ----------------
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [11:0] exp_q[$];   // {win_first, win_last, addr}
    logic [9:0]  acc_q[$];   // addresses accepted by handshake
    int          hs_cnt   = 0;
    bit          chk_en   = 1'b0;
    bit          pend_done = 1'b0;
    int          rdy_mode = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Model: enumerate windows and taps straight from the window-walk definition.
    task automatic build_model(input int w, input int k, input int s);
        exp_q.delete();
        for (int r = 0; r + k <= w; r += s)
            for (int c = 0; c + k <= w; c += s)
                for (int ky = 0; ky < k; ky++)
                    for (int kx = 0; kx < k; kx++)
                        exp_q.push_back({(ky == 0 && kx == 0), (ky == k-1 && kx == k-1),
                                         10'((r + ky) * w + c + kx)});
    endtask

    // ---------------- ready driver ----------------
    initial begin
        addr_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            addr_ready = (rdy_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            chk("next_layer", int'(next_layer), int'(pend_done));
            if (pend_done) chk("valid_in_done", int'(addr_valid), 0);
            pend_done = 1'b0;
            if (addr_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_addr", int'(rd_addr), -1);
                end else begin
                    chk("rd_addr",   int'(rd_addr),   int'(exp_q[0][9:0]));
                    chk("win_first", int'(win_first), int'(exp_q[0][11]));
                    chk("win_last",  int'(win_last),  int'(exp_q[0][10]));
                    if (addr_ready) begin
                        acc_q.push_back(rd_addr);
                        void'(exp_q.pop_front());
                        hs_cnt++;
                        if (exp_q.size() == 0) pend_done = 1'b1;
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic pulse_start(input int w, input int k, input int s);
        @(posedge clk);
        #1;
        input_width  = 5'(w);
        kernal_width = 2'(k);
        stride       = 2'(s);
        start        = 1'b1;
        @(posedge clk);
        #1;
        start        = 1'b0;
        input_width  = 5'($urandom_range(0, 31));
        kernal_width = 2'($urandom_range(0, 3));
        stride       = 2'($urandom_range(0, 3));
    endtask

    // Counts negedges after the start edge until next_layer; bounded.
    task automatic wait_done(input int budget, output int cyc);
        cyc = 0;
        while (1) begin
            @(negedge clk);
            cyc++;
            if (next_layer) break;
            if (cyc > budget) begin
                chk("done_timeout", cyc, budget);
                break;
            end
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_valid"}, int'(addr_valid), 0);
        chk({tag, "_addr"},  int'(rd_addr),    0);
        chk({tag, "_first"}, int'(win_first),  0);
        chk({tag, "_last"},  int'(win_last),   0);
        chk({tag, "_busy"},  int'(busy),       0);
        chk({tag, "_err"},   int'(err),        0);
        chk({tag, "_nl"},    int'(next_layer), 0);
    endtask

    task automatic run_layer(input int w, input int k, input int s, input int mode,
                             input int exp_hs, output int cyc);
        rdy_mode = mode;
        build_model(w, k, s);
        chk("model_size", exp_q.size(), exp_hs);
        acc_q.delete();
        hs_cnt = 0;
        pulse_start(w, k, s);
        wait_done(40000, cyc);
        @(negedge clk);
        chk("handshakes", hs_cnt, exp_hs);
        chk("queue_left", exp_q.size(), 0);
    endtask

    task automatic illegal_cfg(input int w, input int k, input int s);
        int cyc;
        exp_q.delete();
        pulse_start(w, k, s);
        @(negedge clk);
        chk("bad_busy_t1", int'(busy), 1);
        chk("bad_err_t1",  int'(err),  0);
        @(negedge clk);
        chk("bad_err_t2",  int'(err),  1);
        chk("bad_busy_t2", int'(busy), 0);
        cyc = 0;
        repeat (8) begin
            @(negedge clk);
            if (addr_valid) cyc++;
        end
        chk("bad_no_valid", cyc, 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int cyc;
        int pin8[8];
        int pin_end[4];
        pin8    = '{0, 1, 26, 27, 2, 3, 28, 29};
        pin_end = '{648, 649, 674, 675};

        start = 1'b0; input_width = '0; kernal_width = '0; stride = '0;
        reset = 1'b0;
        #1 reset = 1'b1;
        #2 check_zero_outputs("reset");
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        chk_en = 1'b1;

        // W=5 K=1 S=1: 25 back-to-back addresses, next_layer 27 cycles after start.
        run_layer(5, 1, 1, 0, 25, cyc);
        chk("k1_done_cycle", cyc, 27);
        if (acc_q.size() == 25) chk("k1_last_addr", int'(acc_q[24]), 24);
        else chk("k1_acc_size", acc_q.size(), 25);

        // W=26 K=2 S=2 with literal pins on first and last windows.
        run_layer(26, 2, 2, 0, 676, cyc);
        if (acc_q.size() == 676) begin
            for (int i = 0; i < 8; i++) chk("w26_first_addrs", int'(acc_q[i]), pin8[i]);
            for (int i = 0; i < 4; i++) chk("w26_last_addrs", int'(acc_q[672 + i]), pin_end[i]);
        end else chk("w26_acc_size", acc_q.size(), 676);

        // W=28 K=3 S=1 with random backpressure.
        run_layer(28, 3, 1, 1, 6084, cyc);
        if (acc_q.size() == 6084) chk("w28_last_addr", int'(acc_q[6083]), 783);
        else chk("w28_acc_size", acc_q.size(), 6084);
        rdy_mode = 0;

        // Illegal configurations, then a legal start clears err.
        illegal_cfg(2, 3, 1);
        illegal_cfg(9, 2, 0);
        build_model(5, 1, 1);
        hs_cnt = 0;
        pulse_start(5, 1, 1);
        @(negedge clk);
        chk("err_cleared", int'(err), 0);
        wait_done(200, cyc);
        @(negedge clk);
        chk("after_err_hs", hs_cnt, 25);

        // Second start during RUN must be ignored.
        build_model(5, 2, 1);
        hs_cnt = 0;
        pulse_start(5, 2, 1);
        repeat (10) @(negedge clk);
        pulse_start(9, 3, 2);
        wait_done(400, cyc);
        @(negedge clk);
        chk("restart_ignored_hs", hs_cnt, 64);
        chk("restart_queue_left", exp_q.size(), 0);

        // Reset in the middle of W=13 K=3 S=1 after 50 handshakes.
        rdy_mode = 1;
        build_model(13, 3, 1);
        hs_cnt = 0;
        pulse_start(13, 3, 1);
        cyc = 0;
        while (hs_cnt < 50 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        chk("reached_50", int'(hs_cnt >= 50), 1);
        chk_en = 1'b0;
        #1 reset = 1'b1;
        #1 check_zero_outputs("midrun_reset");
        @(posedge clk);
        #2 reset = 1'b0;
        exp_q.delete();
        pend_done = 1'b0;
        chk_en = 1'b1;
        run_layer(13, 3, 1, 1, 1089, cyc);
        if (acc_q.size() > 0) chk("reset_restart_addr0", int'(acc_q[0]), 0);
        else chk("reset_acc_size", acc_q.size(), 1089);
        rdy_mode = 0;

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
